// File: rtl/io_controller.sv
// io_controller: memory-mapped IO block sitting beside data RAM.
// Decodes SW (4096), LED (4097), CYCLE (4098) and BTN (4099); every other
// address goes to RAM. Switches and pushbutton are 2-flop synchronized.
// Optional feature: define IO_DEBOUNCE_EN to add a per-bit debounce counter
// on each synchronized input (DEBOUNCE_CYCLES stable cycles to change).
module io_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wren,
   input  logic        rd_en,
   input  logic [31:0] ram_q,
   input  logic [15:0] sw_in,
   input  logic        btn_in,
   output logic [31:0] q_out,
   output logic        ram_wren,
   output logic [15:0] led
);

   localparam logic [31:0] ADDR_SW    = 32'd4096;
   localparam logic [31:0] ADDR_LED   = 32'd4097;
   localparam logic [31:0] ADDR_CYCLE = 32'd4098;
   localparam logic [31:0] ADDR_BTN   = 32'd4099;

   logic        sel_sw, sel_led, sel_cycle, sel_btn, sel_ram;
   logic [15:0] sw_s1, sw_s2;
   logic        btn_s1, btn_s2;
   logic [15:0] sw_db;
   logic        btn_db;
   logic        btn_prev;
   logic        btn_rise;
   logic        btn_evt;
   logic [7:0]  press_cnt;
   logic [31:0] cycle;

   assign sel_sw    = (addr == ADDR_SW);
   assign sel_led   = (addr == ADDR_LED);
   assign sel_cycle = (addr == ADDR_CYCLE);
   assign sel_btn   = (addr == ADDR_BTN);
   assign sel_ram   = ~(sel_sw | sel_led | sel_cycle | sel_btn);

   assign ram_wren  = wren & sel_ram;

   // Two-flop synchronizers for the asynchronous switch and button inputs
   always_ff @(posedge clock) begin
      if (reset) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         sw_s1  <= sw_in;
         sw_s2  <= sw_s1;
         btn_s1 <= btn_in;
         btn_s2 <= btn_s1;
      end
   end

`ifdef IO_DEBOUNCE_EN
   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [16:0]   sync_vec;
   logic [16:0]   db_q;
   logic [CW-1:0] db_cnt [17];

   assign sync_vec = {btn_s2, sw_s2};

   // Per-bit debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clock) begin
      if (reset) begin
         db_q <= '0;
         for (int unsigned i = 0; i < 17; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 17; i++) begin
            if (sync_vec[i] == db_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               db_q[i]   <= sync_vec[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign sw_db  = db_q[15:0];
   assign btn_db = db_q[16];
`else
   assign sw_db  = sw_s2;
   assign btn_db = btn_s2;
`endif

   assign btn_rise = btn_db & ~btn_prev;

   // LED register: loads on a store to the LED address
   always_ff @(posedge clock) begin
      if (reset) begin
         led <= '0;
      end else if (wren && sel_led) begin
         led <= wdata[15:0];
      end
   end

   // Free-running cycle counter; a store overrides that clock's increment
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle <= '0;
      end else if (wren && sel_cycle) begin
         cycle <= wdata;
      end else begin
         cycle <= cycle + 32'd1;
      end
   end

   // Button press tracking: a store clears, a rising edge beats a clearing read
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_prev  <= 1'b0;
         btn_evt   <= 1'b0;
         press_cnt <= '0;
      end else begin
         btn_prev <= btn_db;
         if (wren && sel_btn) begin
            btn_evt   <= 1'b0;
            press_cnt <= '0;
         end else if (btn_rise) begin
            btn_evt   <= 1'b1;
            press_cnt <= press_cnt + 8'd1;
         end else if (rd_en && sel_btn) begin
            btn_evt <= 1'b0;
         end
      end
   end

   // Read-data mux over registered sources and RAM
   always_comb begin
      q_out = ram_q;
      if (sel_sw) begin
         q_out = {16'h0000, sw_db};
      end else if (sel_led) begin
         q_out = {16'h0000, led};
      end else if (sel_cycle) begin
         q_out = cycle;
      end else if (sel_btn) begin
         q_out = {16'h0000, press_cnt, 7'b0000000, btn_evt};
      end
   end

endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: directed scenarios plus randomized traffic for
// io_controller, checked against a cycle-level behavioural model.
// Honours IO_DEBOUNCE_EN the same way as the design.
module tb_io_controller;

   localparam int unsigned DB = 4;
`ifdef IO_DEBOUNCE_EN
   localparam int unsigned LAT = 2 + DB;
`else
   localparam int unsigned LAT = 2;
`endif
   localparam logic [31:0] A_SW  = 32'd4096;
   localparam logic [31:0] A_LED = 32'd4097;
   localparam logic [31:0] A_CYC = 32'd4098;
   localparam logic [31:0] A_BTN = 32'd4099;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wren;
   logic        rd_en;
   logic [31:0] ram_q;
   logic [15:0] sw_in;
   logic        btn_in;
   logic [31:0] q_out;
   logic        ram_wren;
   logic [15:0] led;

   io_controller #(.DEBOUNCE_CYCLES(DB)) dut (
      .clock    (clock),
      .reset    (reset),
      .addr     (addr),
      .wdata    (wdata),
      .wren     (wren),
      .rd_en    (rd_en),
      .ram_q    (ram_q),
      .sw_in    (sw_in),
      .btn_in   (btn_in),
      .q_out    (q_out),
      .ram_wren (ram_wren),
      .led      (led)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [15:0] m_led   = '0;
   logic [31:0] m_cycle = '0;
   logic        m_evt   = 1'b0;
   logic [7:0]  m_cnt   = '0;
   logic [16:0] m_s1    = '0;
   logic [16:0] m_s2    = '0;
   logic        m_prev  = 1'b0;
`ifdef IO_DEBOUNCE_EN
   logic [16:0] m_db    = '0;
   logic [16:0] hist[$];
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] db_now();
`ifdef IO_DEBOUNCE_EN
      return m_db;
`else
      return m_s2;
`endif
   endfunction

   function automatic logic rise_pending();
      logic [16:0] d;
      d = db_now();
      return d[16] & ~m_prev;
   endfunction

   function automatic logic [31:0] exp_q();
      logic [16:0] d;
      d = db_now();
      if (addr == A_SW)  return {16'h0, d[15:0]};
      if (addr == A_LED) return {16'h0, m_led};
      if (addr == A_CYC) return m_cycle;
      if (addr == A_BTN) return {16'h0, m_cnt, 7'h0, m_evt};
      return ram_q;
   endfunction

   // advance the model by one clock using the inputs present at the edge
   task automatic model_edge();
      logic rise;
      if (reset) begin
         m_led = '0; m_cycle = '0; m_evt = 1'b0; m_cnt = '0;
         m_s1 = '0; m_s2 = '0; m_prev = 1'b0;
`ifdef IO_DEBOUNCE_EN
         m_db = '0;
         hist.delete();
`endif
         return;
      end
      rise   = rise_pending();
      begin
         logic [16:0] d;
         d = db_now();
         m_prev = d[16];
      end
`ifdef IO_DEBOUNCE_EN
      // a bit changes once the last DB synchronized samples all disagree with it
      hist.push_back(m_s2);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
         for (int b = 0; b < 17; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            foreach (hist[k]) if (hist[k][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) m_db[b] = m_s2[b];
         end
      end
`endif
      m_s2 = m_s1;
      m_s1 = {btn_in, sw_in};
      if (wren && addr == A_LED) m_led = wdata[15:0];
      m_cycle = (wren && addr == A_CYC) ? wdata : m_cycle + 32'd1;
      if (wren && addr == A_BTN) begin
         m_evt = 1'b0;
         m_cnt = '0;
      end else if (rise) begin
         m_evt = 1'b1;
         m_cnt = m_cnt + 8'd1;
      end else if (rd_en && addr == A_BTN) begin
         m_evt = 1'b0;
      end
   endtask

   task automatic tick();
      #1;
      check_eq("q_out", q_out, exp_q());
      check_eq("ram_wren", {31'h0, ram_wren}, {31'h0, wren & (addr < A_SW || addr > A_BTN)});
      @(posedge clock);
      model_edge();
      #1;
      check_eq("led", {16'h0, led}, {16'h0, m_led});
   endtask

   task automatic peek(input string tag, input logic [31:0] exp);
      #1;
      check_eq(tag, q_out, exp);
   endtask

   task automatic press();
      btn_in = 1'b1;
      repeat (LAT + 3) tick();
      btn_in = 1'b0;
      repeat (LAT + 3) tick();
   endtask

   initial begin
      reset = 1'b1; addr = 32'd4000; wdata = '0; wren = 1'b0; rd_en = 1'b0;
      ram_q = 32'h5A5A_0001; sw_in = '0; btn_in = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      addr = A_LED; rd_en = 1'b1;
      peek("rst_led_read", 32'h0);
      tick();
      addr = A_BTN;
      peek("rst_btn_read", 32'h0);
      tick();
      rd_en = 1'b0;

      // LED store and RAM store
      addr = A_LED; wren = 1'b1; wdata = 32'h0001_ABCD;
      tick();
      wren = 1'b0;
      check_eq("led_abcd", {16'h0, led}, 32'h0000_ABCD);
      peek("led_read", 32'h0000_ABCD);
      tick();
      addr = 32'd4000; wren = 1'b1;
      #1 check_eq("ram_wren_4000", {31'h0, ram_wren}, 32'h1);
      tick();
      wren = 1'b0;
      check_eq("led_hold", {16'h0, led}, 32'h0000_ABCD);

      // cycle counter load and wrap
      addr = A_CYC; wren = 1'b1; wdata = 32'hFFFF_FFFE;
      tick();
      wren = 1'b0; rd_en = 1'b1;
      peek("cycle_0", 32'hFFFF_FFFE);
      tick();
      peek("cycle_1", 32'hFFFF_FFFF);
      tick();
      peek("cycle_2", 32'h0000_0000);
      tick();
      rd_en = 1'b0;

      // switch latency and glitch rejection
      addr = A_SW; sw_in = 16'h00F0;
      repeat (LAT - 1) tick();
      peek("sw_before", 32'h0);
      tick();
      peek("sw_after", 32'h0000_00F0);
      sw_in = 16'h00F1;
      repeat (3) tick();
      sw_in = 16'h00F0;
      repeat (LAT + 2) tick();
      peek("sw_glitch", 32'h0000_00F0);

      // reset in the middle of a pending switch change
      addr = A_LED; wren = 1'b1; wdata = 32'h0000_1234;
      tick();
      wren = 1'b0;
      check_eq("led_1234", {16'h0, led}, 32'h0000_1234);
      addr = A_SW; sw_in = 16'h0F00;
      repeat (LAT - 1) tick();
      reset = 1'b1; wren = 1'b1; addr = A_LED; wdata = 32'h0000_FFFF;
      tick();
      reset = 1'b0; wren = 1'b0; addr = A_SW;
      check_eq("led_after_reset", {16'h0, led}, 32'h0);
      repeat (LAT - 1) tick();
      peek("sw_rst_pending", 32'h0);
      tick();
      peek("sw_rst_done", 32'h0000_0F00);

      // button presses, clearing reads, coincident press and read
      addr = A_BTN; wren = 1'b1; wdata = '0;
      tick();
      wren = 1'b0; addr = 32'd4000;
      press();
      press();
      addr = A_BTN; rd_en = 1'b1;
      peek("btn_two", 32'h0000_0201);
      tick();
      peek("btn_cleared", 32'h0000_0200);
      tick();
      rd_en = 1'b0; addr = 32'd4000; btn_in = 1'b1;
      for (int i = 0; i < 50 && !rise_pending(); i++) tick();
      check_eq("btn_rise_wait", {31'h0, rise_pending()}, 32'h1);
      addr = A_BTN; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      peek("btn_coincide", 32'h0000_0301);
      btn_in = 1'b0; addr = 32'd4000;
      repeat (LAT + 3) tick();

      // press counter wrap after 256 presses
      addr = A_BTN; wren = 1'b1;
      tick();
      wren = 1'b0; addr = 32'd4000;
      for (int i = 0; i < 256; i++) press();
      addr = A_BTN;
      peek("btn_wrap", 32'h0000_0001);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         int unsigned r;
         r = $urandom_range(0, 7);
         if (r < 4)       addr = A_SW + r;
         else if (r == 4) addr = $urandom;
         else             addr = $urandom_range(0, 4095);
         wren  = ($urandom_range(0, 3) == 0);
         rd_en = ($urandom_range(0, 1) == 1);
         wdata = $urandom;
         ram_q = $urandom;
         if ($urandom_range(0, 9) == 0) sw_in = sw_in ^ 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 7) == 0) btn_in = ~btn_in;
         reset = ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
